// File: rtl/fr_output_streamer.sv
// Output streamer: queues whole result vectors in a small FIFO and serializes them one
// element per beat onto a valid/ready stream. o_last marks the final element of each frame.
// Vectors arriving while the FIFO is full are dropped and flagged by the sticky overflow bit.
module fr_output_streamer #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NUM_OUT = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [NUM_OUT*DATA_W-1:0]  in_data,
  output logic                       in_ready,
  output logic [DATA_W-1:0]          o_data,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic                       o_last,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int unsigned VecW = NUM_OUT * DATA_W;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned IdxW = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [VecW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q;

  state_e          state_q;
  logic [VecW-1:0] vec_q;     // shift register; element being sent sits in the low slice
  logic [IdxW-1:0] idx_q;
  logic            o_valid_q, o_last_q;

  logic            push, pop, beat_done, last_done;
  logic [VecW-1:0] head, vec_shift;
  logic [IdxW-1:0] idx_nxt;

  // Full/empty come from the registered count only, so a same-cycle pop cannot admit a write.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign o_valid   = o_valid_q;
  assign o_last    = o_last_q;
  assign o_data    = vec_q[DATA_W-1:0];

  // Handshake decode and FIFO occupancy next-state.
  always_comb begin
    push      = in_valid & in_ready;
    beat_done = o_valid_q & o_ready;
    last_done = beat_done & o_last_q;
    // Refill the shift register when idle, or on the last beat so frames run back to back.
    pop       = (count_q != '0) & ((state_q == StIdle) | last_done);
    head      = mem_q[rd_ptr_q];
    vec_shift = vec_q >> DATA_W;
    idx_nxt   = idx_q + IdxW'(1);
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Read FSM with registered stream outputs; nothing changes while a beat is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      vec_q     <= '0;
      idx_q     <= '0;
      o_valid_q <= 1'b0;
      o_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            state_q   <= StSend;
            vec_q     <= head;
            idx_q     <= '0;
            o_valid_q <= 1'b1;
            o_last_q  <= (NUM_OUT == 1);
          end
        end
        StSend: begin
          if (beat_done) begin
            if (!o_last_q) begin
              vec_q    <= vec_shift;
              idx_q    <= idx_nxt;
              o_last_q <= (idx_nxt == IdxW'(NUM_OUT - 1));
            end else if (pop) begin
              vec_q    <= head;
              idx_q    <= '0;
              o_last_q <= (NUM_OUT == 1);
            end else begin
              state_q   <= StIdle;
              o_valid_q <= 1'b0;
              o_last_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          o_valid_q <= 1'b0;
          o_last_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fr_output_streamer.sv
// Scoreboard bench for fr_output_streamer: a cycle-level reference of queue occupancy decides
// which vectors are accepted; accepted elements go to an expected-beat queue that a separate
// monitor drains whenever the DUT completes a handshake.
module tb_fr_output_streamer;

  localparam int DW    = 16;
  localparam int NO    = 2;
  localparam int DEPTH = 4;
  localparam int VW    = NO * DW;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       in_valid;
  logic [VW-1:0]              in_data;
  logic                       in_ready;
  logic [DW-1:0]              o_data;
  logic                       o_valid;
  logic                       o_ready;
  logic                       o_last;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;

  fr_output_streamer #(.DATA_W(DW), .NUM_OUT(NO), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .o_last   (o_last),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Reference state: queued vectors, whether a frame is being sent, beats left in it.
  int    cnt_m   = 0;
  bit    busy_m  = 0;
  int    left_m  = 0;
  bit    ovf_m   = 0;
  bit    started = 0;
  bit    rst_edge = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model, advanced on every clock edge from the stimulus alone.
  always @(posedge clk) begin
    bit last_hs, pop_m, push_m;
    beat_t b;
    rst_edge = rst;
    if (rst) begin
      started = 1;
      cnt_m   = 0;
      busy_m  = 0;
      left_m  = 0;
      ovf_m   = 0;
      exp_q.delete();
    end else if (started) begin
      last_hs = busy_m && o_ready && (left_m == 1);
      pop_m   = (cnt_m != 0) && (!busy_m || last_hs);
      push_m  = in_valid && (cnt_m < DEPTH);
      if (in_valid && !push_m) ovf_m = 1;
      if (push_m) begin
        for (int k = 0; k < NO; k++) begin
          b.d = in_data[k*DW +: DW];
          b.l = (k == NO - 1);
          exp_q.push_back(b);
        end
      end
      if (busy_m && o_ready) left_m--;
      if (pop_m) begin
        busy_m = 1;
        left_m = NO;
      end else if (last_hs) begin
        busy_m = 0;
      end
      cnt_m = cnt_m + int'(push_m) - int'(pop_m);
    end
  end

  // Monitor: mid-cycle checks of status outputs, stall stability and delivered beats.
  bit            hold_prev = 0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  always @(negedge clk) begin
    beat_t e;
    if (started) begin
      chk("count", 32'(count), 32'(cnt_m));
      chk("in_ready", 32'(in_ready), 32'(cnt_m < DEPTH));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      chk("o_valid", 32'(o_valid), 32'(busy_m));
      if (rst_edge) begin
        chk("rst_o_last", 32'(o_last), 32'(0));
        chk("rst_o_data", 32'(o_data), 32'(0));
      end else if (hold_prev) begin
        chk("hold_valid", 32'(o_valid), 32'(1));
        chk("hold_data", 32'(o_data), 32'(hold_d));
        chk("hold_last", 32'(o_last), 32'(hold_l));
      end
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(o_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(o_data), 32'(e.d));
          chk("beat_last", 32'(o_last), 32'(e.l));
        end
      end
      hold_prev = o_valid && !o_ready;
      hold_d    = o_data;
      hold_l    = o_last;
    end
  end

  task automatic step(input logic iv, input logic [VW-1:0] d, input logic ordy);
    in_valid = iv;
    in_data  = d;
    o_ready  = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    o_ready  = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame: 120 then 80.
    step(1'b1, {16'sd80, 16'sd120}, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);

    // Backpressure while the first beat is presented.
    step(1'b1, {16'sd80, 16'sd120}, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (5) step(1'b0, '0, 1'b0);
    repeat (5) step(1'b0, '0, 1'b1);

    // Overflow: six vectors with the stream stalled; the sixth is dropped.
    for (int i = 1; i <= 6; i++) step(1'b1, {16'(i * 10), 16'(i)}, 1'b0);
    repeat (3) step(1'b0, '0, 1'b0);
    repeat (14) step(1'b0, '0, 1'b1);

    // Back-to-back frames with the sink always ready.
    step(1'b1, {16'h1111, 16'h2222}, 1'b1);
    step(1'b1, {16'h3333, 16'h4444}, 1'b1);
    repeat (8) step(1'b0, '0, 1'b1);

    // Signed bit patterns pass through unchanged.
    step(1'b1, {16'h8000, 16'hFFFB}, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);

    // Reset while beat 1 of a frame is pending and two vectors are queued.
    for (int i = 0; i < 3; i++) step(1'b1, {16'(16'hA0 + i), 16'(16'hB0 + i)}, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1);
    step(1'b1, {16'h0BEE, 16'h0CAF}, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);

    // Randomized traffic with random backpressure and rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 99) < 45), VW'($urandom), ($urandom_range(0, 99) < 65));
      end
    end

    repeat (20) step(1'b0, '0, 1'b1);
    chk("drain_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
